// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter indices, symbol values and the A..Z pattern table.
// Patterns hold the first symbol in bit num, the last symbol in bit 0, upper bits 0.
package morse_pkg;

   localparam logic [4:0] LTR_A = 5'd1,  LTR_B = 5'd2,  LTR_C = 5'd3,  LTR_D = 5'd4;
   localparam logic [4:0] LTR_E = 5'd5,  LTR_F = 5'd6,  LTR_G = 5'd7,  LTR_H = 5'd8;
   localparam logic [4:0] LTR_I = 5'd9,  LTR_J = 5'd10, LTR_K = 5'd11, LTR_L = 5'd12;
   localparam logic [4:0] LTR_M = 5'd13, LTR_N = 5'd14, LTR_O = 5'd15, LTR_P = 5'd16;
   localparam logic [4:0] LTR_Q = 5'd17, LTR_R = 5'd18, LTR_S = 5'd19, LTR_T = 5'd20;
   localparam logic [4:0] LTR_U = 5'd21, LTR_V = 5'd22, LTR_W = 5'd23, LTR_X = 5'd24;
   localparam logic [4:0] LTR_Y = 5'd25, LTR_Z = 5'd26;

   localparam int NUM_LETTERS = 26;

   localparam logic SYM_DOT  = 1'b0;
   localparam logic SYM_DASH = 1'b1;

   typedef struct packed {
      logic [3:0] code;
      logic [1:0] num;
   } pattern_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MARK,
      ST_SPACE,
      ST_EMIT
   } state_t;

   function automatic pattern_t pattern_of(input logic [4:0] ltr);
      case (ltr)
         LTR_A:   pattern_of = '{code: 4'b0001, num: 2'd1};
         LTR_B:   pattern_of = '{code: 4'b1000, num: 2'd3};
         LTR_C:   pattern_of = '{code: 4'b1010, num: 2'd3};
         LTR_D:   pattern_of = '{code: 4'b0100, num: 2'd2};
         LTR_E:   pattern_of = '{code: 4'b0000, num: 2'd0};
         LTR_F:   pattern_of = '{code: 4'b0010, num: 2'd3};
         LTR_G:   pattern_of = '{code: 4'b0110, num: 2'd2};
         LTR_H:   pattern_of = '{code: 4'b0000, num: 2'd3};
         LTR_I:   pattern_of = '{code: 4'b0000, num: 2'd1};
         LTR_J:   pattern_of = '{code: 4'b0111, num: 2'd3};
         LTR_K:   pattern_of = '{code: 4'b0101, num: 2'd2};
         LTR_L:   pattern_of = '{code: 4'b0100, num: 2'd3};
         LTR_M:   pattern_of = '{code: 4'b0011, num: 2'd1};
         LTR_N:   pattern_of = '{code: 4'b0010, num: 2'd1};
         LTR_O:   pattern_of = '{code: 4'b0111, num: 2'd2};
         LTR_P:   pattern_of = '{code: 4'b0110, num: 2'd3};
         LTR_Q:   pattern_of = '{code: 4'b1101, num: 2'd3};
         LTR_R:   pattern_of = '{code: 4'b0010, num: 2'd2};
         LTR_S:   pattern_of = '{code: 4'b0000, num: 2'd2};
         LTR_T:   pattern_of = '{code: 4'b0001, num: 2'd0};
         LTR_U:   pattern_of = '{code: 4'b0001, num: 2'd2};
         LTR_V:   pattern_of = '{code: 4'b0001, num: 2'd3};
         LTR_W:   pattern_of = '{code: 4'b0011, num: 2'd2};
         LTR_X:   pattern_of = '{code: 4'b1001, num: 2'd3};
         LTR_Y:   pattern_of = '{code: 4'b1011, num: 2'd3};
         LTR_Z:   pattern_of = '{code: 4'b1100, num: 2'd3};
         default: pattern_of = '{code: 4'b1111, num: 2'd3};
      endcase
   endfunction

endpackage

// File: rtl/morse_code_decoder_if.sv
// Key line and decoded-letter bundle between a Morse source and the decoder.
interface morse_code_decoder_if;
   logic       key_in;
   logic [4:0] alpha_out;
   logic [1:0] num_out;
   logic [3:0] code_out;
   logic       valid_out;
   logic       err_out;

   modport master (
      output key_in,
      input  alpha_out, num_out, code_out, valid_out, err_out
   );

   modport slave (
      input  key_in,
      output alpha_out, num_out, code_out, valid_out, err_out
   );
endinterface

// File: rtl/morse_lookup.sv
// Combinational reverse lookup of a dot/dash pattern to its letter index.
// hit=0 (alpha=0) when the pattern is not one of A..Z.
module morse_lookup
   import morse_pkg::*;
(
   input  logic [3:0] code,
   input  logic [1:0] num,
   output logic [4:0] alpha,
   output logic       hit
);

   pattern_t key;
   assign key = '{code: code, num: num};

   always_comb begin
      alpha = '0;
      hit   = 1'b0;
      for (int i = 1; i <= NUM_LETTERS; i++) begin
         if (pattern_of(5'(i)) == key) begin
            alpha = 5'(i);
            hit   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/morse_code_decoder.sv
// Morse receiver: synchronizes the key line, times marks/spaces, collects up to
// four symbols per letter and emits the letter index once a letter gap elapses.
module morse_code_decoder
   import morse_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int DOT_MAX    = 3,
   parameter int LETTER_GAP = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   morse_code_decoder_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
   localparam logic [CNT_W-1:0] GAP_LEN = CNT_W'(LETTER_GAP);

   logic             key_p0, key_p1;
   logic             key_s;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [3:0]       shift_reg;
   logic [2:0]       sym_cnt;
   logic             overflow;
   logic             sym_bit;
   logic [1:0]       num_now;
   logic [4:0]       lk_alpha;
   logic             lk_hit;

   logic [4:0]       alpha_r;
   logic [1:0]       num_r;
   logic [3:0]       code_r;
   logic             valid_r;
   logic             err_r;

   // stage p0/p1: two-flop synchronizer on the asynchronous key line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_p0 <= 1'b0;
         key_p1 <= 1'b0;
      end else begin
         key_p0 <= bus.key_in;
         key_p1 <= key_p0;
      end
   end

   assign key_s    = key_p1;
   assign cnt_inc  = cnt + 1'b1;
   assign overflow = (sym_cnt == 3'd5);
   assign sym_bit  = (cnt > DOT_LIM) ? SYM_DASH : SYM_DOT;
   // Overflowed letters report the four symbols that were kept.
   assign num_now  = overflow ? 2'd3 : 2'(sym_cnt - 3'd1);

   morse_lookup u_lookup (
      .code  (shift_reg),
      .num   (num_now),
      .alpha (lk_alpha),
      .hit   (lk_hit)
   );

   // stage p2: timing FSM with registered letter outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         shift_reg <= '0;
         sym_cnt   <= '0;
         alpha_r   <= '0;
         num_r     <= '0;
         code_r    <= '0;
         valid_r   <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (key_s) begin
                  state     <= ST_MARK;
                  cnt       <= CNT_W'(1);
                  sym_cnt   <= '0;
                  shift_reg <= '0;
               end
            end
            ST_MARK: begin
               if (key_s) begin
                  if (cnt != CNT_MAX) cnt <= cnt_inc;
               end else begin
                  if (sym_cnt < 3'd4) shift_reg <= {shift_reg[2:0], sym_bit};
                  if (!overflow)      sym_cnt   <= sym_cnt + 3'd1;
                  cnt   <= CNT_W'(1);
                  state <= ST_SPACE;
               end
            end
            ST_SPACE: begin
               // A returning mark takes priority over reaching the gap length.
               if (key_s) begin
                  cnt   <= CNT_W'(1);
                  state <= ST_MARK;
               end else if (cnt_inc == GAP_LEN) begin
                  state   <= ST_EMIT;
                  valid_r <= 1'b1;
                  err_r   <= overflow | ~lk_hit;
                  alpha_r <= (overflow | ~lk_hit) ? 5'd0 : lk_alpha;
                  num_r   <= num_now;
                  code_r  <= shift_reg;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_EMIT: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.alpha_out = alpha_r;
   assign bus.num_out   = num_r;
   assign bus.code_out  = code_r;
   assign bus.valid_out = valid_r;
   assign bus.err_out   = err_r;

endmodule

// File: tb/tb_morse_code_decoder.sv
// Scoreboard bench for the Morse decoder: letters are keyed as high/low run
// lengths, expected letters are queued and checked by a negedge monitor.
module tb_morse_code_decoder;

   localparam int CNT_W      = 8;
   localparam int DOT_MAX    = 3;
   localparam int LETTER_GAP = 8;
   localparam int PAD        = 4;

   typedef struct {
      logic [4:0] a;
      logic [1:0] n;
      logic [3:0] c;
      logic       e;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   morse_code_decoder_if bus ();

   morse_code_decoder #(
      .CNT_W      (CNT_W),
      .DOT_MAX    (DOT_MAX),
      .LETTER_GAP (LETTER_GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every valid_out pulse must match the oldest queued letter.
   always @(negedge clk) begin
      if (bus.valid_out === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_valid cycle %0d: valid_out=1 alpha=%0d, required no output", cyc, bus.alpha_out);
         end else begin
            exp_t x;
            x = sb.pop_front();
            n_cmp++;
            if (bus.alpha_out !== x.a) begin
               n_err++;
               $display("FAIL alpha_out: got %0d, required %0d", bus.alpha_out, x.a);
            end
            n_cmp++;
            if (bus.num_out !== x.n) begin
               n_err++;
               $display("FAIL num_out (alpha %0d): got %0d, required %0d", x.a, bus.num_out, x.n);
            end
            n_cmp++;
            if (bus.code_out !== x.c) begin
               n_err++;
               $display("FAIL code_out (alpha %0d): got %b, required %b", x.a, bus.code_out, x.c);
            end
            n_cmp++;
            if (bus.err_out !== x.e) begin
               n_err++;
               $display("FAIL err_out (alpha %0d): got %b, required %b", x.a, bus.err_out, x.e);
            end
            n_cmp++;
            if (cyc !== x.cyc) begin
               n_err++;
               $display("FAIL valid_cycle (alpha %0d): got cycle %0d, required %0d", x.a, cyc, x.cyc);
            end
         end
      end
   end

   task automatic drive(input logic lvl, input int n);
      bus.key_in = lvl;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_raw(input int d[$]);
      for (int i = 0; i < d.size(); i++) drive((i % 2) == 0, d[i]);
   endtask

   // Last run is the closing gap; the letter is due LETTER_GAP+2 edges after it starts.
   task automatic send_letter(input int d[$], input logic [4:0] a, input logic [1:0] n,
                              input logic [3:0] c, input logic e);
      exp_t x;
      for (int i = 0; i < d.size() - 1; i++) drive((i % 2) == 0, d[i]);
      x.a   = a;
      x.n   = n;
      x.c   = c;
      x.e   = e;
      x.cyc = cyc + LETTER_GAP + 2;
      sb.push_back(x);
      drive(1'b0, d[d.size() - 1] + PAD);
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL %s drain: %0d letters still pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic check_zero_outputs(input string name);
      n_cmp++;
      if (bus.alpha_out !== 5'd0) begin
         n_err++;
         $display("FAIL %s alpha_out: got %0d, required 0", name, bus.alpha_out);
      end
      n_cmp++;
      if (bus.num_out !== 2'd0) begin
         n_err++;
         $display("FAIL %s num_out: got %0d, required 0", name, bus.num_out);
      end
      n_cmp++;
      if (bus.code_out !== 4'd0) begin
         n_err++;
         $display("FAIL %s code_out: got %b, required 0000", name, bus.code_out);
      end
      n_cmp++;
      if (bus.valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL %s valid_out: got %b, required 0", name, bus.valid_out);
      end
      n_cmp++;
      if (bus.err_out !== 1'b0) begin
         n_err++;
         $display("FAIL %s err_out: got %b, required 0", name, bus.err_out);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      bus.key_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst = 1'b0;
      drive(1'b0, 4);
      check_zero_outputs("post_reset_idle");
   endtask

   task automatic test_single();
      send_letter('{2, 8}, 5'd5, 2'd0, 4'b0000, 1'b0);
      send_letter('{3, 8}, 5'd5, 2'd0, 4'b0000, 1'b0);
      send_letter('{4, 8}, 5'd20, 2'd0, 4'b0001, 1'b0);
      wait_drain("single");
   endtask

   task automatic test_multi();
      send_letter('{5, 2, 2, 8}, 5'd14, 2'd1, 4'b0010, 1'b0);
      send_letter('{5, 2, 5, 2, 2, 8}, 5'd7, 2'd2, 4'b0110, 1'b0);
      send_letter('{5, 2, 5, 2, 2, 2, 5, 8}, 5'd17, 2'd3, 4'b1101, 1'b0);
      send_letter('{2, 2, 2, 2, 2, 2, 5, 8}, 5'd22, 2'd3, 4'b0001, 1'b0);
      wait_drain("multi");
   endtask

   task automatic test_errors();
      send_letter('{2, 2, 2, 2, 2, 2, 2, 2, 2, 8}, 5'd0, 2'd3, 4'b0000, 1'b1);
      send_letter('{2, 2, 2, 2, 5, 2, 5, 8}, 5'd0, 2'd3, 4'b0011, 1'b1);
      // A clean letter right after errors must clear err_out.
      send_letter('{2, 2, 5, 8}, 5'd1, 2'd1, 4'b0001, 1'b0);
      wait_drain("errors");
   endtask

   task automatic test_gap_boundary();
      // Key returns in what would be the 8th low cycle: same letter continues.
      send_letter('{2, 7, 2, 8}, 5'd9, 2'd1, 4'b0000, 1'b0);
      // Exactly LETTER_GAP lows splits into two letters.
      send_letter('{2, 8}, 5'd5, 2'd0, 4'b0000, 1'b0);
      send_letter('{5, 8}, 5'd20, 2'd0, 4'b0001, 1'b0);
      wait_drain("gap_boundary");
   endtask

   task automatic test_reset_mid();
      send_raw('{5, 2, 1});
      rst = 1'b1;
      #1;
      check_zero_outputs("reset_mid");
      bus.key_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, 4);
      send_letter('{2, 8}, 5'd5, 2'd0, 4'b0000, 1'b0);
      wait_drain("reset_mid");
   endtask

   task automatic test_long_hold();
      send_letter('{40, 8}, 5'd20, 2'd0, 4'b0001, 1'b0);
      send_letter('{300, 2, 2, 8}, 5'd14, 2'd1, 4'b0010, 1'b0);
      wait_drain("long_hold");
   endtask

   task automatic test_back_to_back();
      send_letter('{2, 8}, 5'd5, 2'd0, 4'b0000, 1'b0);
      drive(1'b0, 30);
      send_letter('{5, 2, 5, 2, 2, 2, 2, 8}, 5'd26, 2'd3, 4'b1100, 1'b0);
      send_letter('{5, 2, 5, 2, 5, 8}, 5'd15, 2'd2, 4'b0111, 1'b0);
      send_letter('{2, 2, 2, 2, 2, 8}, 5'd19, 2'd2, 4'b0000, 1'b0);
      wait_drain("back_to_back");
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_errors();
      test_gap_boundary();
      test_reset_mid();
      test_long_hold();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/morse_code_decoder.md
Name: morse_code_decoder

Overview:
Receive-side counterpart of the Morse encoder. Samples a single on/off key line and times each mark (key high) and space (key low). Classifies marks as dot or dash and assembles up to 4 symbols per letter. Emits the letter index on the same alpha/num encoding the encoder consumes: alpha 1=A..26=Z, num = symbol count - 1.

Parameters:
CNT_W, 8, width of the mark/space duration counter; saturates at 2**CNT_W-1
DOT_MAX, 3, longest mark in synchronized cycles still classed as a dot; longer marks are dashes
LETTER_GAP, 8, consecutive synchronized-low cycles that terminate a letter; must be > 1 and < 2**CNT_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
key_in  input  1  raw Morse key line (1 = mark); asynchronous to clk
alpha_out  output  5  decoded letter, 1..26; 0 when err_out=1
num_out  output  2  symbols in letter minus 1 (00 = 1 symbol .. 11 = 4 symbols)
code_out  output  4  symbol pattern, dot=0, dash=1; first symbol in bit num_out, last in bit 0, unused upper bits 0
valid_out  output  1  one-cycle pulse: alpha/num/code/err updated this cycle
err_out  output  1  letter was >4 symbols or not an A-Z pattern

Behaviour:
- Reset: already decided, one clock, async active-high. rst=1 clears synchronizer, counters, shift register, symbol count and FSM immediately. All outputs are 0 until the first valid_out.
- Input path: 2-flop synchronizer on key_in, giving key_s. All timing counts key_s cycles. Edge-to-FSM latency is 2 cycles.
- FSM states: IDLE, MARK, SPACE, EMIT.
- IDLE: wait for key_s=1, then go to MARK with cnt=1 and symbol count=0.
- MARK: cnt++ (saturating) while key_s=1. On key_s=0, shift in symbol (1 if cnt>DOT_MAX, else 0), increment symbol count, go to SPACE with cnt=1.
- Symbol count 5+: set sticky overflow. Shift register keeps the first 4 symbols; the count saturates at 5.
- SPACE: cnt++ while key_s=0. If key_s=1 before cnt reaches LETTER_GAP, go to MARK with cnt=1 (same letter). When cnt==LETTER_GAP with key_s=0, go to EMIT.
- Simultaneous events: key_s=1 in the cycle cnt would reach LETTER_GAP means MARK wins and no emit happens.
- EMIT (1 cycle): drive valid_out=1 and register outputs from lookup. Outputs hold until the next EMIT. Then go to IDLE.
- Error case: overflow or lookup miss gives err_out=1, alpha_out=0. num_out and code_out still reflect the truncated pattern (num_out=11 on overflow).
- Latency: valid_out asserts the cycle after the LETTER_GAP-th consecutive low key_s cycle.
- Mark held indefinitely: cnt saturates, no emission until release plus gap.
- Spaces longer than LETTER_GAP (word gaps): no extra output. The FSM stays in IDLE.
- rst mid-letter: partial letter is discarded and no valid_out is produced.

Decomposition:
- morse_pkg: letter index constants (LTR_A=5'd1 .. LTR_Z=5'd26), dot/dash symbol values, the 26-entry pattern table (code, len).
- Sub-module morse_lookup: combinational (code[3:0], num[1:0]) -> (alpha[4:0], hit). It is reusable by the encoder bench as a reference model.
- The decoder holds the synchronizer, counter, shift register and FSM.

Test Plan (defaults; "Nh" = key_in high N cycles, "Nl" = low N cycles):
- E: 2h, 8l -> one valid_out pulse, alpha_out=5, num_out=00, code_out=0000, err_out=0; pulse 1 cycle after 8th low key_s cycle.
- N: 5h, 2l, 2h, 8l -> alpha_out=14, num_out=01, code_out=0010. G: 5h,2l,5h,2l,2h,8l -> alpha_out=7, num_out=10, code_out=0110.
- Q: 5h,2l,5h,2l,2h,2l,5h,8l -> alpha_out=17, num_out=11, code_out=1101; then DOT_MAX boundary: 3h,8l -> E; 4h,8l -> T (alpha_out=20, code_out=0001).
- Overflow: five 2h/2l dots then 8l -> err_out=1, alpha_out=0, num_out=11, code_out=0000. Miss: pattern "..--" (2h,2l,2h,2l,5h,2l,5h,8l) -> err_out=1, alpha_out=0, code_out=0011.
- Gap boundary: 2h, 7l, 2h, 8l -> single letter I (alpha_out=9, num_out=01); key rising exactly at 8th low cycle -> no emit, letter continues.
- Reset: assert rst mid-mark of N -> outputs 0 immediately; after release, 2h,8l -> E with no stale symbols; 40h hold -> no valid_out until gap.
